lc3_lockstep_checker: RTL and testbench

- Synthesisable N-channel lockstep checker for LC3 memory-bus traffic.
- Generalises the two-core side-by-side harness to N_CH cores.
- Each core's bus transactions are buffered in a per-channel FIFO. When every enabled channel has a transaction waiting, the heads are compared against the reference channel.
- Reports mismatches, skew timeouts and overflow. Sits beside the cores on the shared clock, observing their memwe/mar/mdr/memOut traffic.

---
 rtl/lc3_chk_pkg.sv | 24 ++
 rtl/lc3_chk_fifo.sv | 47 ++++
 rtl/lc3_lockstep_checker.sv | 141 ++++++++++++++
 tb/tb_lc3_lockstep_checker.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_chk_pkg.sv
// Shared types and helpers for the LC3 N-channel lockstep checker.
package lc3_chk_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 16;
  localparam int unsigned MaxCh    = 8;

  typedef struct packed {
    logic                we;
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] data;
  } txn_t;

  // Lowest-index enabled channel; 0 when nothing is enabled.
  function automatic logic [2:0] ref_index(input logic [MaxCh-1:0] mask);
    logic [2:0] idx;
    idx = '0;
    for (int i = MaxCh - 1; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lc3_chk_fifo.sv
// Single-channel transaction FIFO; a push into a full FIFO lands only if it pops at the same edge.
module lc3_chk_fifo
  import lc3_chk_pkg::*;
#(
  parameter type         T     = txn_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [PtrW:0]  wr_q;
  logic [PtrW:0]  rd_q;
  logic           do_push;
  logic           do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem_q[wr_q[PtrW-1:0]] <= din;
  end

endmodule

// File: rtl/lc3_lockstep_checker.sv
// N-channel lockstep checker: buffers each core's bus traffic and compares FIFO heads
// against the lowest-index enabled channel once every enabled channel has one waiting.
module lc3_lockstep_checker
  import lc3_chk_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clr,
  input  logic [N_CH-1:0]                en_mask,
  input  logic [N_CH-1:0]                ch_valid,
  input  logic [N_CH-1:0]                ch_we,
  input  logic [N_CH-1:0][ADDR_W-1:0]    ch_addr,
  input  logic [N_CH-1:0][DATA_W-1:0]    ch_data,
  output logic                           cmp_valid,
  output logic                           mismatch,
  output logic [N_CH-1:0]                mm_mask,
  output logic [ADDR_W-1:0]              mm_addr,
  output logic [CNT_W-1:0]               mm_index,
  output logic [CNT_W-1:0]               compare_count,
  output logic [CNT_W-1:0]               mismatch_count,
  output logic [N_CH-1:0]                overflow,
  output logic                           timeout
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ch_txn_t;

  localparam int unsigned SkewW = $clog2(TIMEOUT + 1);

  logic              sync_clr;
  ch_txn_t           head [N_CH];
  logic [N_CH-1:0]   empty;
  logic [N_CH-1:0]   full;
  logic [N_CH-1:0]   push;
  logic [N_CH-1:0]   pop;
  logic [N_CH-1:0]   ovf_evt;
  logic [MaxCh-1:0]  en_ext;
  logic [2:0]        ref_idx;
  ch_txn_t           ref_txn;
  logic              any_en;
  logic              all_ready;
  logic              pending;
  logic              do_cmp;
  logic [N_CH-1:0]   diff;
  logic              mm_now;
  logic [SkewW-1:0]  skew_q;

  assign sync_clr = reset | clr;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_txn_t din;
    assign din        = '{we: ch_we[i], addr: ch_addr[i], data: ch_data[i]};
    assign push[i]    = ch_valid[i] & en_mask[i];
    assign pop[i]     = do_cmp & en_mask[i];
    assign ovf_evt[i] = push[i] & full[i] & ~pop[i];

    lc3_chk_fifo #(
      .T     (ch_txn_t),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (sync_clr),
      .flush (~en_mask[i]),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (din),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  always_comb begin
    en_ext             = '0;
    en_ext[N_CH-1:0]   = en_mask;
    ref_idx            = ref_index(en_ext);
    any_en             = |en_mask;
    ref_txn            = head[0];
    all_ready          = 1'b1;
    pending            = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (3'(i) == ref_idx) ref_txn = head[i];
      if (en_mask[i]) begin
        if (empty[i]) all_ready = 1'b0;
        else          pending   = 1'b1;
      end
    end
    do_cmp = any_en && all_ready;
    diff   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      diff[i] = en_mask[i] && (head[i] != ref_txn);
    end
    mm_now = do_cmp && (|diff);
  end

  always_ff @(posedge clk) begin
    if (sync_clr) begin
      cmp_valid      <= 1'b0;
      mismatch       <= 1'b0;
      mm_mask        <= '0;
      mm_addr        <= '0;
      mm_index       <= '0;
      compare_count  <= '0;
      mismatch_count <= '0;
      overflow       <= '0;
      timeout        <= 1'b0;
      skew_q         <= '0;
    end else begin
      cmp_valid <= do_cmp;
      overflow  <= overflow | ovf_evt;
      if (do_cmp && compare_count != '1) compare_count <= compare_count + 1'b1;
      if (mm_now) begin
        if (mismatch_count != '1) mismatch_count <= mismatch_count + 1'b1;
        if (!mismatch) begin
          mismatch <= 1'b1;
          mm_mask  <= diff;
          mm_addr  <= ref_txn.addr;
          mm_index <= compare_count;
        end
      end
      // Skew only accumulates while something waits and no compare drains it.
      if (!any_en || do_cmp || !pending) begin
        skew_q <= '0;
      end else if (skew_q != SkewW'(TIMEOUT)) begin
        skew_q <= skew_q + 1'b1;
        if (skew_q == SkewW'(TIMEOUT - 1)) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lc3_lockstep_checker.sv
// Scoreboard bench for lc3_lockstep_checker with a queue-based reference model.
module tb_lc3_lockstep_checker;

  localparam int unsigned NCh  = 3;
  localparam int unsigned Dep  = 4;
  localparam int unsigned To   = 20;
  localparam int unsigned CntW = 4;
  localparam int          CMax = 15;

  logic                 clk;
  logic                 reset;
  logic                 clr;
  logic [NCh-1:0]       en_mask;
  logic [NCh-1:0]       ch_valid;
  logic [NCh-1:0]       ch_we;
  logic [NCh-1:0][15:0] ch_addr;
  logic [NCh-1:0][15:0] ch_data;
  logic                 cmp_valid;
  logic                 mismatch;
  logic [NCh-1:0]       mm_mask;
  logic [15:0]          mm_addr;
  logic [CntW-1:0]      mm_index;
  logic [CntW-1:0]      compare_count;
  logic [CntW-1:0]      mismatch_count;
  logic [NCh-1:0]       overflow;
  logic                 timeout;

  lc3_lockstep_checker #(
    .N_CH    (NCh),
    .DATA_W  (16),
    .ADDR_W  (16),
    .DEPTH   (Dep),
    .TIMEOUT (To),
    .CNT_W   (CntW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clr            (clr),
    .en_mask        (en_mask),
    .ch_valid       (ch_valid),
    .ch_we          (ch_we),
    .ch_addr        (ch_addr),
    .ch_data        (ch_data),
    .cmp_valid      (cmp_valid),
    .mismatch       (mismatch),
    .mm_mask        (mm_mask),
    .mm_addr        (mm_addr),
    .mm_index       (mm_index),
    .compare_count  (compare_count),
    .mismatch_count (mismatch_count),
    .overflow       (overflow),
    .timeout        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } mtxn_t;

  typedef struct packed {
    logic [3:0]  cc;
    logic [3:0]  mc;
    logic        mm;
    logic [2:0]  mmask;
    logic [15:0] maddr;
    logic [3:0]  midx;
  } exp_t;

  exp_t  sb [$];
  mtxn_t mq [NCh][$];
  int    n_pass  = 0;
  int    n_total = 0;

  int          m_cc, m_mc, m_midx, m_skew;
  bit          m_mm, m_to, m_cmp_prev;
  bit [2:0]    m_mmask, m_ovf;
  bit [15:0]   m_maddr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int sat(input int v);
    return (v > CMax) ? CMax : v;
  endfunction

  // Reference model: one edge of the checker, evaluated on the inputs about to be sampled.
  task automatic model_step();
    bit    cmp, pending;
    int    r;
    mtxn_t h [NCh];
    bit [2:0] d;
    if (reset || clr) begin
      for (int i = 0; i < NCh; i++) mq[i].delete();
      m_cc = 0; m_mc = 0; m_midx = 0; m_skew = 0;
      m_mm = 0; m_to = 0; m_cmp_prev = 0; m_mmask = 0; m_ovf = 0; m_maddr = 0;
      return;
    end
    cmp = (en_mask != 0);
    pending = 0;
    for (int i = 0; i < NCh; i++) begin
      if (en_mask[i]) begin
        if (mq[i].size() == 0) cmp = 0;
        else pending = 1;
      end
    end
    if (cmp) begin
      r = -1;
      for (int i = 0; i < NCh; i++) if (en_mask[i] && r < 0) r = i;
      for (int i = 0; i < NCh; i++) if (en_mask[i]) h[i] = mq[i].pop_front();
      d = 0;
      for (int i = 0; i < NCh; i++) if (en_mask[i] && h[i] != h[r]) d[i] = 1;
      if (d != 0) begin
        if (!m_mm) begin
          m_mm = 1; m_mmask = d; m_maddr = h[r].addr; m_midx = m_cc;
        end
        m_mc = sat(m_mc + 1);
      end
      m_cc = sat(m_cc + 1);
      sb.push_back('{cc: 4'(m_cc), mc: 4'(m_mc), mm: m_mm, mmask: m_mmask,
                     maddr: m_maddr, midx: 4'(m_midx)});
    end
    for (int i = 0; i < NCh; i++) begin
      if (!en_mask[i]) mq[i].delete();
      else if (ch_valid[i]) begin
        if (mq[i].size() < Dep) mq[i].push_back('{we: ch_we[i], addr: ch_addr[i], data: ch_data[i]});
        else m_ovf[i] = 1;
      end
    end
    if (en_mask != 0 && !cmp && pending) begin
      if (m_skew < To) m_skew++;
      if (m_skew == To) m_to = 1;
    end else begin
      m_skew = 0;
    end
    m_cmp_prev = cmp;
  endtask

  // Called at a negedge with inputs set; checks last edge's flags, models the next edge.
  task automatic tick();
    check("cmp_valid", 32'(cmp_valid), 32'(m_cmp_prev));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("timeout", 32'(timeout), 32'(m_to));
    model_step();
    @(negedge clk);
    ch_valid = '0;
  endtask

  task automatic put(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    ch_valid[i] = 1'b1;
    ch_we[i]    = we;
    ch_addr[i]  = a;
    ch_data[i]  = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cmp_valid"}, 32'(cmp_valid), 0);
    check({tag, "_mismatch"}, 32'(mismatch), 0);
    check({tag, "_mm_mask"}, 32'(mm_mask), 0);
    check({tag, "_mm_addr"}, 32'(mm_addr), 0);
    check({tag, "_mm_index"}, 32'(mm_index), 0);
    check({tag, "_cmp_cnt"}, 32'(compare_count), 0);
    check({tag, "_mm_cnt"}, 32'(mismatch_count), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  // Monitor: pops an expectation for every comparison the DUT reports.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && cmp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_cmp", 32'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        check("sb_cmp_cnt", 32'(compare_count), 32'(e.cc));
        check("sb_mm_cnt", 32'(mismatch_count), 32'(e.mc));
        check("sb_mismatch", 32'(mismatch), 32'(e.mm));
        check("sb_mm_mask", 32'(mm_mask), 32'(e.mmask));
        check("sb_mm_addr", 32'(mm_addr), 32'(e.maddr));
        check("sb_mm_index", 32'(mm_index), 32'(e.midx));
      end
    end
  end

  int unsigned seq [NCh];

  initial begin
    reset = 1'b1; clr = 1'b0; en_mask = '0; ch_valid = '0; ch_we = '0;
    ch_addr = '0; ch_data = '0;
    repeat (2) @(negedge clk);
    model_step();
    reset = 1'b0;
    check_zero("reset");

    // Identical writes on the same cycle; compare one edge later.
    en_mask = 3'b011;
    put(0, 1'b1, 16'h3000, 16'h1234);
    put(1, 1'b1, 16'h3000, 16'h1234);
    tick();
    check("lat_no_cmp_yet", 32'(cmp_valid), 0);
    tick();
    check("lat_cmp_valid", 32'(cmp_valid), 1);
    check("t1_cmp_cnt", 32'(compare_count), 1);
    check("t1_mismatch", 32'(mismatch), 0);

    // First mismatch capture, then a second that must not overwrite it.
    do_clr();
    put(0, 1'b1, 16'h3001, 16'h1234);
    put(1, 1'b1, 16'h3001, 16'h1235);
    tick(); tick();
    check("t2_mismatch", 32'(mismatch), 1);
    check("t2_mm_mask", 32'(mm_mask), 32'h2);
    check("t2_mm_addr", 32'(mm_addr), 32'h3001);
    check("t2_mm_index", 32'(mm_index), 0);
    put(0, 1'b0, 16'h3002, 16'h0005);
    put(1, 1'b0, 16'h3002, 16'h0006);
    tick(); tick();
    check("t2_mm_cnt", 32'(mismatch_count), 2);
    check("t2_mm_addr_hold", 32'(mm_addr), 32'h3001);
    check("t2_mm_index_hold", 32'(mm_index), 0);

    // Ch1 replays ch0's three transactions two cycles late.
    do_clr();
    put(0, 1'b1, 16'h3100, 16'hA); tick();
    put(0, 1'b0, 16'h3101, 16'hB); tick();
    put(0, 1'b1, 16'h3102, 16'hC); put(1, 1'b1, 16'h3100, 16'hA); tick();
    put(1, 1'b0, 16'h3101, 16'hB); tick();
    put(1, 1'b1, 16'h3102, 16'hC); tick();
    idle(3);
    check("t3_cmp_cnt", 32'(compare_count), 3);
    check("t3_mismatch", 32'(mismatch), 0);
    check("t3_timeout", 32'(timeout), 0);

    // Overflow on the fifth push into a depth-4 FIFO, then skew timeout.
    do_clr();
    for (int k = 0; k < 5; k++) begin
      put(0, 1'b1, 16'(16'h3200 + k), 16'(k));
      tick();
    end
    check("t4_overflow", 32'(overflow), 32'h1);
    idle(To);
    check("t4_timeout", 32'(timeout), 1);

    // Clear mid-stream with partial FIFOs, then fresh traffic counts from zero.
    do_clr();
    put(0, 1'b1, 16'h3300, 16'h1); tick();
    put(0, 1'b1, 16'h3301, 16'h2); tick();
    do_clr();
    check_zero("clr");
    put(0, 1'b0, 16'h3400, 16'h77); put(1, 1'b0, 16'h3400, 16'h77);
    tick(); tick();
    check("t6_cmp_cnt", 32'(compare_count), 1);
    check("t6_mismatch", 32'(mismatch), 0);

    // Ch0 disabled and sending garbage; ch1 becomes reference.
    do_clr();
    en_mask = 3'b110;
    for (int k = 0; k < 3; k++) begin
      put(0, 1'b1, 16'hDEAD, 16'(k * 7 + 3));
      put(1, 1'b1, 16'(16'h3500 + k), 16'(k));
      put(2, 1'b1, 16'(16'h3500 + k), 16'(k));
      tick();
    end
    idle(2);
    en_mask = 3'b111;
    put(0, 1'b0, 16'h3600, 16'h9); put(1, 1'b0, 16'h3600, 16'h9); put(2, 1'b0, 16'h3600, 16'h9);
    tick(); tick();
    check("t5_cmp_cnt", 32'(compare_count), 4);
    check("t5_mismatch", 32'(mismatch), 0);

    // Single enabled channel compares against itself.
    do_clr();
    en_mask = 3'b100;
    for (int k = 0; k < 3; k++) begin
      put(2, 1'b1, 16'(k), 16'(k ^ 5));
      tick();
    end
    idle(2);
    check("single_cmp_cnt", 32'(compare_count), 3);
    check("single_mismatch", 32'(mismatch), 0);

    // Counter saturation.
    do_clr();
    en_mask = 3'b011;
    for (int k = 0; k < 18; k++) begin
      put(0, 1'b0, 16'(k), 16'(k)); put(1, 1'b0, 16'(k), 16'(k)); tick();
    end
    idle(2);
    check("sat_cmp_cnt", 32'(compare_count), 32'hF);
    for (int k = 0; k < 18; k++) begin
      put(0, 1'b0, 16'(k), 16'(k)); put(1, 1'b0, 16'(k), 16'(k + 1)); tick();
    end
    idle(2);
    check("sat_mm_cnt", 32'(mismatch_count), 32'hF);
    check("sat_mm_index", 32'(mm_index), 32'hF);

    // Randomised traffic with occasional corruption, mask changes and clears.
    do_clr();
    for (int i = 0; i < NCh; i++) seq[i] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 60 == 0) en_mask = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin
        do_clr();
        for (int i = 0; i < NCh; i++) seq[i] = 0;
      end
      for (int i = 0; i < NCh; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          put(i, seq[i][0], 16'(16'h4000 + seq[i]),
              16'((seq[i] * 3 + 16'h100) ^ (($urandom_range(0, 15) == 0) ? 1 : 0)));
          seq[i]++;
        end
      end
      tick();
    end
    idle(5);
    check("sb_drain", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
